stu_context_copy_engine: RTL and testbench
==========================================

# stu_context_copy_engine

Responder side of the L2 context-copy handshake issued by the STU fork controller. On a copy-start pulse it streams the master core's (core 0) architectural integer registers into the selected speculative core's register file, writes the speculative start PC, and then pulses copy-done. A squash of the target core aborts the transfer. It sits between the fork controller and the per-core register-file access ports.

## Interface
- NUM_REGS, 32, architectural registers copied; must be a multiple of REGS_PER_CYCLE
- REGS_PER_CYCLE, 2, registers moved per cycle (lanes); G = NUM_REGS/REGS_PER_CYCLE groups
- Reset rst, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst  in  1  async active-low reset
- copy_start_in  in  1  start pulse from fork controller
- spec_core_id_in  in  stu_pkg::core_id_t  target core, sampled with start
- spec_pc_in  in  stu_pkg::addr_t  speculative start PC, sampled with start
- abort_in  in  1  squash of target core (already indexed by fork controller)
- src_rd_en_out  out  1  master regfile read strobe
- src_rd_addr_out  out  REGS_PER_CYCLE x stu_pkg::reg_idx_t  read indices
- src_rd_data_in  in  REGS_PER_CYCLE x stu_pkg::XLEN  read data, valid 1 cycle after strobe
- dst_core_id_out  out  stu_pkg::core_id_t  latched target core
- dst_wr_en_out  out  REGS_PER_CYCLE  per-lane write enable
- dst_wr_addr_out  out  REGS_PER_CYCLE x stu_pkg::reg_idx_t  write indices
- dst_wr_data_out  out  REGS_PER_CYCLE x stu_pkg::XLEN  write data
- dst_pc_wr_en_out  out  1  PC write strobe
- dst_pc_out  out  stu_pkg::addr_t  latched spec PC
- dst_wr_ready_in  in  1  target port accepts register/PC write this cycle
- copy_done_out  out  1  one-cycle completion pulse
- busy_out  out  1  state != IDLE

## Operation
- States: IDLE, COPY, PC_WRITE, FINISH.
- IDLE: copy_start_in=1 latches core id and PC, clears read/write group counters, -> COPY. abort_in ignored in IDLE.
- COPY: read issue rule: rd_issue = groups_read < G && (!wr_valid || dst_wr_ready_in). Group k reads registers k*REGS_PER_CYCLE + lane.
- Returned data loads the write stage (wr_valid=1) the next cycle; write stage holds outputs stable while dst_wr_ready_in=0. No skid buffer needed: a read is issued only when the write stage drains that cycle.
- After the last group is written (accepted with ready=1) -> PC_WRITE.
- PC_WRITE: dst_pc_wr_en_out=1 until dst_wr_ready_in=1, then -> FINISH.
- FINISH: copy_done_out=1 for one cycle, -> IDLE.
- Abort: abort_in=1 in COPY/PC_WRITE/FINISH has priority over all else: every enable and copy_done_out forced 0 that cycle, pending write discarded, -> IDLE.
- copy_start_in outside IDLE ignored.
- Group counters are $clog2(G)+1 bits; no wrap occurs.

## Timing
- Reset: every output 0, state IDLE, latched id/PC 0, wr_valid 0.
- No backpressure, start in cycle 0: reads cycles 1..G, writes cycles 2..G+1, PC write cycle G+2, copy_done_out cycle G+3 (19 for defaults).
- Each ready=0 cycle on a valid write or PC write adds exactly one cycle.
- src_rd_data_in sampled exactly one cycle after src_rd_en_out.
- Reset mid-operation: immediate return to reset values; no done.

## Configuration
- STU_CTX_SKIP_X0_EN: defined -> lane writing register 0 has dst_wr_en_out bit forced 0 (x0 hardwired); the other lanes in that group write normally and timing is unchanged. Undefined -> x0 written like every register, data forced to 0.

## Structure
- stu_pkg additions: XLEN, REG_IDX_BITS=5, reg_idx_t, ctx_state_t enum; reuse existing core_id_t, addr_t.
- Single module; the write stage is a few registers and does not justify a sub-module.

## Test plan
- Start with core 2, PC 0x1000, ready tied 1, src data = 0xA000_0000+index -> 16 write cycles with correct data, PC write 0x1000 at cycle 18, done at cycle 19.
- ready=0 for 3 cycles during group 5 -> outputs held stable, no reads issued, done at cycle 22.
- abort_in during group 7 -> enables drop that cycle, IDLE next, no done, no PC write; new start then completes normally.
- abort_in in FINISH cycle -> copy_done_out stays 0.
- Second start while busy -> ignored, first copy completes unchanged; rst deasserted mid-copy -> all outputs 0 immediately.
- STU_CTX_SKIP_X0_EN on/off -> lane 0 of group 0 enable 0 / 1 (data 0), latency identical.

Source files
------------

// File: rtl/stu_pkg.sv
// -----------------------------------------------------------------------------
// stu_pkg
// Shared types for the STU (speculative thread unit) blocks.
//   core_id_t   : core index (4 cores, core 0 is the master)
//   addr_t      : instruction address
//   XLEN        : architectural integer register width
//   reg_idx_t   : architectural register index (32 registers)
//   ctx_state_t : context-copy engine states
// -----------------------------------------------------------------------------
package stu_pkg;

   localparam int unsigned NUM_CORES    = 4;
   localparam int unsigned CORE_ID_BITS = 2;
   localparam int unsigned ADDR_BITS    = 32;
   localparam int unsigned XLEN         = 32;
   localparam int unsigned REG_IDX_BITS = 5;

   typedef logic [CORE_ID_BITS-1:0] core_id_t;
   typedef logic [ADDR_BITS-1:0]    addr_t;
   typedef logic [REG_IDX_BITS-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      CTX_IDLE     = 2'd0,
      CTX_COPY     = 2'd1,
      CTX_PC_WRITE = 2'd2,
      CTX_FINISH   = 2'd3
   } ctx_state_t;

endpackage

// File: rtl/stu_context_copy_engine.sv
// -----------------------------------------------------------------------------
// stu_context_copy_engine
// Responder side of the L2 context-copy handshake. On copy_start_in it streams
// the master core's integer registers, REGS_PER_CYCLE per cycle, into the
// selected speculative core's register file, writes the speculative start PC,
// then pulses copy_done_out. abort_in (outside IDLE) cancels the transfer.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   copy_start_in      start pulse; samples spec_core_id_in / spec_pc_in
//   abort_in           squash of the target core
//   src_rd_*           master register-file read port (data 1 cycle later)
//   dst_core_id_out    latched target core
//   dst_wr_*           per-lane target register-file write port
//   dst_pc_*           target PC write port
//   dst_wr_ready_in    target accepts the register/PC write this cycle
//   copy_done_out      one-cycle completion pulse
//   busy_out           engine not idle
//
// Build option: STU_CTX_SKIP_X0_EN -- when defined, the lane carrying register 0
// keeps its write enable low (x0 is hardwired in the target); otherwise x0 is
// written with data forced to zero.
// -----------------------------------------------------------------------------
module stu_context_copy_engine
   import stu_pkg::*;
#(
   parameter int unsigned NUM_REGS       = 32,
   parameter int unsigned REGS_PER_CYCLE = 2
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         copy_start_in,
   input  core_id_t                                     spec_core_id_in,
   input  addr_t                                        spec_pc_in,
   input  logic                                         abort_in,
   output logic                                         src_rd_en_out,
   output logic [REGS_PER_CYCLE-1:0][REG_IDX_BITS-1:0]  src_rd_addr_out,
   input  logic [REGS_PER_CYCLE-1:0][XLEN-1:0]          src_rd_data_in,
   output core_id_t                                     dst_core_id_out,
   output logic [REGS_PER_CYCLE-1:0]                    dst_wr_en_out,
   output logic [REGS_PER_CYCLE-1:0][REG_IDX_BITS-1:0]  dst_wr_addr_out,
   output logic [REGS_PER_CYCLE-1:0][XLEN-1:0]          dst_wr_data_out,
   output logic                                         dst_pc_wr_en_out,
   output addr_t                                        dst_pc_out,
   input  logic                                         dst_wr_ready_in,
   output logic                                         copy_done_out,
   output logic                                         busy_out
);

   localparam int unsigned     G      = NUM_REGS / REGS_PER_CYCLE;
   localparam int unsigned     CNT_W  = $clog2(G) + 1;
   localparam logic [CNT_W-1:0] G_CNT  = CNT_W'(G);
   localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G - 1);

   typedef logic [REGS_PER_CYCLE-1:0][XLEN-1:0]         lane_data_t;
   typedef logic [REGS_PER_CYCLE-1:0][REG_IDX_BITS-1:0] lane_idx_t;

   ctx_state_t        state_q, state_d;
   core_id_t          core_id_q, core_id_d;
   addr_t             pc_q, pc_d;
   logic [CNT_W-1:0]  rd_grp_q, rd_grp_d;
   logic [CNT_W-1:0]  wr_grp_q, wr_grp_d;
   logic              wr_valid_q, wr_valid_d;
   logic              wr_fresh_q, wr_fresh_d;
   lane_idx_t         wr_addr_q, wr_addr_d;
   lane_data_t        hold_q, hold_d;

   logic              rd_issue;
   logic              wr_accept;
   logic              wr_en_ok;
   logic              pc_wr_en;
   logic              done;
   lane_idx_t         rd_addr;
   lane_data_t        wr_data_cur;

   // The write stage takes data straight off the read bus in the cycle after
   // the read (fresh); if the target stalls, that data is captured into hold_q
   // so the outputs stay stable after the source bus moves on.
   always_comb begin
      wr_data_cur = wr_fresh_q ? src_rd_data_in : hold_q;
      for (int unsigned l = 0; l < REGS_PER_CYCLE; l++) begin
         rd_addr[l] = REG_IDX_BITS'(32'(rd_grp_q) * REGS_PER_CYCLE + l);
      end
   end

   always_comb begin
      state_d    = state_q;
      core_id_d  = core_id_q;
      pc_d       = pc_q;
      rd_grp_d   = rd_grp_q;
      wr_grp_d   = wr_grp_q;
      wr_valid_d = wr_valid_q;
      wr_fresh_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      hold_d     = wr_data_cur;
      rd_issue   = 1'b0;
      wr_accept  = 1'b0;
      wr_en_ok   = 1'b0;
      pc_wr_en   = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         CTX_IDLE: begin
            wr_valid_d = 1'b0;
            if (copy_start_in) begin
               core_id_d = spec_core_id_in;
               pc_d      = spec_pc_in;
               rd_grp_d  = '0;
               wr_grp_d  = '0;
               state_d   = CTX_COPY;
            end
         end

         CTX_COPY: begin
            if (abort_in) begin
               wr_valid_d = 1'b0;
               state_d    = CTX_IDLE;
            end else begin
               wr_en_ok  = wr_valid_q;
               wr_accept = wr_valid_q && dst_wr_ready_in;
               // A read is issued only when the write stage drains this cycle,
               // so the returning data always finds the stage free.
               rd_issue  = (rd_grp_q < G_CNT) && (!wr_valid_q || dst_wr_ready_in);
               if (rd_issue) begin
                  rd_grp_d   = rd_grp_q + 1'b1;
                  wr_valid_d = 1'b1;
                  wr_fresh_d = 1'b1;
                  wr_addr_d  = rd_addr;
               end else if (wr_accept) begin
                  wr_valid_d = 1'b0;
               end
               if (wr_accept) begin
                  wr_grp_d = wr_grp_q + 1'b1;
                  if (wr_grp_q == G_LAST) begin
                     state_d = CTX_PC_WRITE;
                  end
               end
            end
         end

         CTX_PC_WRITE: begin
            wr_valid_d = 1'b0;
            if (abort_in) begin
               state_d = CTX_IDLE;
            end else begin
               pc_wr_en = 1'b1;
               if (dst_wr_ready_in) begin
                  state_d = CTX_FINISH;
               end
            end
         end

         CTX_FINISH: begin
            wr_valid_d = 1'b0;
            done       = !abort_in;
            state_d    = CTX_IDLE;
         end

         default: begin
            wr_valid_d = 1'b0;
            state_d    = CTX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= CTX_IDLE;
         core_id_q  <= '0;
         pc_q       <= '0;
         rd_grp_q   <= '0;
         wr_grp_q   <= '0;
         wr_valid_q <= 1'b0;
         wr_fresh_q <= 1'b0;
         wr_addr_q  <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         core_id_q  <= core_id_d;
         pc_q       <= pc_d;
         rd_grp_q   <= rd_grp_d;
         wr_grp_q   <= wr_grp_d;
         wr_valid_q <= wr_valid_d;
         wr_fresh_q <= wr_fresh_d;
         wr_addr_q  <= wr_addr_d;
         hold_q     <= hold_d;
      end
   end

   always_comb begin
      src_rd_en_out    = rd_issue;
      src_rd_addr_out  = rd_issue ? rd_addr : '0;
      dst_wr_addr_out  = wr_valid_q ? wr_addr_q : '0;
      dst_wr_en_out    = '0;
      dst_wr_data_out  = '0;
      for (int unsigned l = 0; l < REGS_PER_CYCLE; l++) begin
`ifdef STU_CTX_SKIP_X0_EN
         dst_wr_en_out[l]   = wr_en_ok && (wr_addr_q[l] != '0);
         dst_wr_data_out[l] = wr_valid_q ? wr_data_cur[l] : '0;
`else
         dst_wr_en_out[l]   = wr_en_ok;
         dst_wr_data_out[l] = (wr_valid_q && (wr_addr_q[l] != '0)) ? wr_data_cur[l] : '0;
`endif
      end
      dst_pc_wr_en_out = pc_wr_en;
      dst_pc_out       = pc_q;
      dst_core_id_out  = core_id_q;
      copy_done_out    = done;
      busy_out         = (state_q != CTX_IDLE);
   end

endmodule

// File: tb/tb_stu_context_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_stu_context_copy_engine
// Self-checking bench for stu_context_copy_engine (default parameters).
// A small synchronous memory model returns 0xA000_0000 + index one cycle after
// each read strobe and 0xDEAD_BEEF otherwise, so held write data is exercised.
// -----------------------------------------------------------------------------
module tb_stu_context_copy_engine;
   import stu_pkg::*;

   localparam int unsigned NR = 32;
   localparam int unsigned RP = 2;

   logic                          clk;
   logic                          rst;
   logic                          copy_start_in;
   core_id_t                      spec_core_id_in;
   addr_t                         spec_pc_in;
   logic                          abort_in;
   logic                          src_rd_en_out;
   logic [RP-1:0][REG_IDX_BITS-1:0] src_rd_addr_out;
   logic [RP-1:0][XLEN-1:0]       src_rd_data_in;
   core_id_t                      dst_core_id_out;
   logic [RP-1:0]                 dst_wr_en_out;
   logic [RP-1:0][REG_IDX_BITS-1:0] dst_wr_addr_out;
   logic [RP-1:0][XLEN-1:0]       dst_wr_data_out;
   logic                          dst_pc_wr_en_out;
   addr_t                         dst_pc_out;
   logic                          dst_wr_ready_in;
   logic                          copy_done_out;
   logic                          busy_out;

   int errors = 0;
   int checks = 0;

   stu_context_copy_engine #(
      .NUM_REGS       (NR),
      .REGS_PER_CYCLE (RP)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .copy_start_in    (copy_start_in),
      .spec_core_id_in  (spec_core_id_in),
      .spec_pc_in       (spec_pc_in),
      .abort_in         (abort_in),
      .src_rd_en_out    (src_rd_en_out),
      .src_rd_addr_out  (src_rd_addr_out),
      .src_rd_data_in   (src_rd_data_in),
      .dst_core_id_out  (dst_core_id_out),
      .dst_wr_en_out    (dst_wr_en_out),
      .dst_wr_addr_out  (dst_wr_addr_out),
      .dst_wr_data_out  (dst_wr_data_out),
      .dst_pc_wr_en_out (dst_pc_wr_en_out),
      .dst_pc_out       (dst_pc_out),
      .dst_wr_ready_in  (dst_wr_ready_in),
      .copy_done_out    (copy_done_out),
      .busy_out         (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Master register file: registered read, data valid the cycle after strobe.
   always @(posedge clk) begin
      for (int l = 0; l < RP; l++) begin
         src_rd_data_in[l] <= src_rd_en_out ? (32'hA000_0000 + 32'(src_rd_addr_out[l]))
                                            : 32'hDEAD_BEEF;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic any_output();
      return |{src_rd_en_out, src_rd_addr_out, dst_core_id_out, dst_wr_en_out,
               dst_wr_addr_out, dst_wr_data_out, dst_pc_wr_en_out, dst_pc_out,
               copy_done_out, busy_out};
   endfunction

   typedef struct {
      string name;
      int    stall_at;   // first cycle with ready=0 (-1 none)
      int    stall_len;
      int    abort_at;   // cycle with abort_in=1 (-1 none)
      int    start2_at;  // cycle of an extra start pulse while busy (-1 none)
      int    exp_done;   // cycle of copy_done_out (-1 none)
      int    exp_pc;     // cycle the PC write is accepted (-1 none)
      int    exp_wr;     // accepted register-write groups
      int    exp_rd;     // issued read groups
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      int done_c, pc_c, nwr, nrd;
      int a;
      logic [31:0] exp_d;
      logic [RP-1:0] exp_en;
      done_c = -1; pc_c = -1; nwr = 0; nrd = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
         copy_start_in   = (c == 0) || (c == v.start2_at);
         spec_core_id_in = (c == 0) ? core_id_t'(2) : core_id_t'(1);
         spec_pc_in      = (c == 0) ? 32'h0000_1000 : 32'h0000_2000;
         dst_wr_ready_in = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
         abort_in        = (c == v.abort_at);
         @(negedge clk);
         if (src_rd_en_out) begin
            for (int l = 0; l < RP; l++) begin
               check({v.name, ".rd_addr"}, 64'(src_rd_addr_out[l]), 64'(nrd * RP + l));
            end
            nrd++;
         end
         if (|dst_wr_en_out) begin
            check({v.name, ".core_id"}, 64'(dst_core_id_out), 64'(2));
            for (int l = 0; l < RP; l++) begin
               a = nwr * RP + l;
`ifdef STU_CTX_SKIP_X0_EN
               exp_en[l] = (a != 0);
`else
               exp_en[l] = 1'b1;
`endif
               exp_d = (a == 0) ? 32'h0 : 32'hA000_0000 + 32'(a);
               check({v.name, ".wr_addr"}, 64'(dst_wr_addr_out[l]), 64'(a));
               if (exp_en[l]) check({v.name, ".wr_data"}, 64'(dst_wr_data_out[l]), 64'(exp_d));
            end
            check({v.name, ".wr_en"}, 64'(dst_wr_en_out), 64'(exp_en));
            if (dst_wr_ready_in) nwr++;
            else check({v.name, ".rd_in_stall"}, 64'(src_rd_en_out), 64'(0));
         end
         if (dst_pc_wr_en_out) begin
            check({v.name, ".pc"}, 64'(dst_pc_out), 64'h1000);
            if (dst_wr_ready_in) pc_c = c;
         end
         if (copy_done_out) done_c = (done_c == -1) ? c : -2;
         if (v.abort_at >= 0 && c == v.abort_at)
            check({v.name, ".abort_quiet"},
                  64'({src_rd_en_out, |dst_wr_en_out, dst_pc_wr_en_out, copy_done_out}), 64'(0));
         if (v.abort_at >= 0 && c == v.abort_at + 1)
            check({v.name, ".abort_idle"}, 64'(busy_out), 64'(0));
         @(posedge clk); #1;
      end
      copy_start_in = 1'b0; abort_in = 1'b0; dst_wr_ready_in = 1'b1;
      check({v.name, ".done_cycle"}, 64'(done_c), 64'(v.exp_done));
      check({v.name, ".pc_cycle"},   64'(pc_c),   64'(v.exp_pc));
      check({v.name, ".wr_groups"},  64'(nwr),    64'(v.exp_wr));
      check({v.name, ".rd_groups"},  64'(nrd),    64'(v.exp_rd));
      check({v.name, ".idle_after"}, 64'(busy_out), 64'(0));
   endtask

   initial begin
      //          name            stall len abort st2 done pc  wr  rd
      vecs[0] = '{"plain",         -1, 0,   -1,  -1, 19,  18, 16, 16};
      vecs[1] = '{"stall_g5",       7, 3,   -1,  -1, 22,  21, 16, 16};
      vecs[2] = '{"stall_g0",       2, 1,   -1,  -1, 20,  19, 16, 16};
      vecs[3] = '{"stall_pc",      18, 2,   -1,  -1, 21,  20, 16, 16};
      vecs[4] = '{"abort_g7",      -1, 0,    9,  -1, -1,  -1,  7,  8};
      vecs[5] = '{"after_abort",   -1, 0,   -1,  -1, 19,  18, 16, 16};
      vecs[6] = '{"abort_finish",  -1, 0,   19,  -1, -1,  18, 16, 16};
      vecs[7] = '{"start_busy",    -1, 0,   -1,   5, 19,  18, 16, 16};

      rst = 1'b0;
      copy_start_in = 1'b0;
      spec_core_id_in = '0;
      spec_pc_in = '0;
      abort_in = 1'b0;
      dst_wr_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'(any_output()), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_idle", 64'(any_output()), 64'(0));

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset asserted mid-copy: outputs clear immediately, no done afterwards.
      @(posedge clk); #1;
      copy_start_in = 1'b1; spec_core_id_in = core_id_t'(2); spec_pc_in = 32'h1000;
      @(posedge clk); #1;
      copy_start_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("busy_before_rst", 64'(busy_out), 64'(1));
      rst = 1'b0;
      #1;
      check("rst_midcopy_outputs", 64'(any_output()), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      begin
         int seen_done;
         seen_done = 0;
         for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (copy_done_out || busy_out) seen_done++;
         end
         check("rst_no_done", 64'(seen_done), 64'(0));
      end
      run_vec(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
